// File: rtl/comm_tx_scheduler.sv
// Round-robin arbiter feeding a single serial transmitter: one start bit (0),
// eight data bits MSB first, one stop bit (1), each bit held BIT_TICKS clocks.
module comm_tx_scheduler #(
    parameter int NREQ      = 4,
    parameter int BIT_TICKS = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       data_in,
    input  logic                    tx_en,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic                    serial_out,
    output logic [$clog2(NREQ)-1:0] cur_src
);

    localparam int SW = $clog2(NREQ);
    localparam int TW = $clog2(BIT_TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [SW-1:0] SRC_LAST  = SW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      sh_q, sh_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            serial_q, serial_d;
    logic [SW-1:0]   cur_src_q, cur_src_d;

    logic            win_valid;
    logic [SW-1:0]   win_idx;
    logic            tick_end;

    // Winner is the first asserted request at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = int'(rr_ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_valid && req[SW'(idx)]) begin
                win_valid = 1'b1;
                win_idx   = SW'(idx);
            end
        end
    end

    assign tick_end = (tick_q == TICK_LAST);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = '0;
        busy_d    = busy_q;
        serial_d  = serial_q;
        cur_src_d = cur_src_q;

        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (tx_en && win_valid) begin
                    sh_d      = data_in[{win_idx, 3'b000} +: 8];
                    grant_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    cur_src_d = win_idx;
                    rr_ptr_d  = (win_idx == SRC_LAST) ? '0 : win_idx + 1'b1;
                    serial_d  = 1'b0;
                    busy_d    = 1'b1;
                    tick_d    = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (tick_end) begin
                    tick_d   = '0;
                    bit_d    = '0;
                    serial_d = sh_q[7];
                    state_d  = DATA;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            DATA: begin
                if (tick_end) begin
                    tick_d = '0;
                    if (bit_q == 3'd7) begin
                        serial_d = 1'b1;
                        state_d  = STOP;
                    end else begin
                        bit_d    = bit_q + 1'b1;
                        sh_d     = {sh_q[6:0], 1'b0};
                        serial_d = sh_q[6];
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            STOP: begin
                if (tick_end) begin
                    tick_d  = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            tick_q    <= '0;
            bit_q     <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            serial_q  <= 1'b1;
            cur_src_q <= '0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            serial_q  <= serial_d;
            cur_src_q <= cur_src_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = busy_q;
    assign serial_out = serial_q;
    assign cur_src    = cur_src_q;

endmodule
